qsn_shift_sched_pc15: RTL and testbench
=======================================

// Module: qsn_shift_sched_pc15
// PURPOSE
// Scheduler and controller for the Pc=15 QSN cyclic shifter: left shifter, right shifter and the 15-lane merge stage.
// Two requesters share one QSN instance:
//   - req0: VNU-side message path.
//   - req1: CNU-side message path.
// Each request carries a shift factor and a burst length. The block arbitrates round-robin and locks the network for the burst.
// It drives registered left/right shift amounts and the 14-bit merge select for every burst beat.
// PARAMETERS
// PC        15  QSN size (lanes); merge select is PC-1 bits wide
// SHIFT_W   4   shift-factor width, ceil(log2(PC))
// LEN_W     6   burst-length field width; burst beats = len+1 (1..64)
// PORTS
// sys_clk      in   1          single clock, rising edge
// rstn         in   1          asynchronous active-low reset
// req0_valid   in   1          requester 0 has a burst request
// req0_shift   in   SHIFT_W    requester 0 shift factor, 0..PC-1
// req0_len     in   LEN_W      requester 0 burst length minus 1
// req0_ready   out  1          requester 0 request accepted this cycle
// req1_valid   in   1          requester 1 request (same fields as req0)
// req1_shift   in   SHIFT_W    requester 1 shift factor
// req1_len     in   LEN_W      requester 1 burst length minus 1
// req1_ready   out  1          requester 1 request accepted this cycle
// left_shift   out  SHIFT_W    left-shifter amount = s
// right_shift  out  SHIFT_W    right-shifter amount = (s==0) ? 0 : PC-s
// merge_sel    out  PC-1       merge-stage select; bit i = 1 iff i < PC-1-s
// net_valid    out  1          current beat is valid; QSN output is to be captured
// net_owner    out  1          requester owning the current beat
// net_last     out  1          final beat of the burst
// busy         out  1          FSM is not in IDLE
// BEHAVIOUR
// - Reset (rstn=0, async): all outputs 0, FSM=IDLE, rr_ptr=0 (requester 0 has priority first).
// - Handshake: a request is accepted in the cycle reqX_valid && reqX_ready.
//   - reqX_ready is combinational, asserted only in IDLE or in the BUSY last-beat cycle (back-to-back bursts), for the single granted requester.
//   - Requesters hold valid and fields stable until ready.
// - Arbitration: if only one requester is valid, it is granted. If both are valid, grant goes to rr_ptr.
//   - rr_ptr is set to the non-granted requester on every accept.
// - FSM:
//   - IDLE -> BUSY on accept.
//   - BUSY -> BUSY on a last beat with a new accept.
//   - BUSY -> IDLE on a last beat with no accept.
// - Latency: shift and select outputs are registered. The first beat (net_valid=1) appears in the cycle after accept.
//   - The beat counter loads len and decrements each beat. net_last=1 when the counter is 0.
// - Throughput: one beat per cycle. Back-to-back bursts have zero bubble cycles between them.
// - left_shift, right_shift, merge_sel and net_owner stay constant over a burst.
//   - They hold their last value in IDLE. net_valid=0 in IDLE.
// - Shift s=0: merge_sel = all ones, right_shift=0. s=14: merge_sel = all zeros, right_shift=1.
// - len=0 gives a single-beat burst: net_valid and net_last are both 1 in the same cycle.
// - Counter arithmetic is LEN_W bits, unsigned. The counter never wraps; the decrement is inhibited at 0.
// - Reset asserted mid-burst aborts immediately: outputs go to 0 and the burst is not resumed.
// CONFIGURATION
// QSN_SCHED_SHIFT_CHECK_EN:
//   - Defined: an accepted shift >= PC is replaced by 0.
//     - Extra output shift_err (1 bit) is set in the cycle after the accept and is sticky until reset.
//   - Not defined: no shift_err port. An out-of-range shift is passed through unchecked and the result is undefined.
// TESTING
// 1. Reset, then req0 valid with s=3, len=2 -> first beat next cycle; 3 beats; left=3, right=12, merge_sel=14'h07FF; net_last on beat 3.
// 2. req0 and req1 valid in the same cycle right after reset -> req0 granted first. req1 is accepted in req0's last beat and its first beat follows with no bubble; net_owner goes 0 -> 1.
// 3. Both requesters valid continuously, len=0 -> grants alternate 0,1,0,1; net_valid=1 every cycle.
// 4. s=0 then s=14 -> merge_sel=14'h3FFF, right=0; then merge_sel=14'h0000, left=14, right=1.
// 5. rstn low during beat 2 of a 5-beat burst -> all outputs 0 asynchronously; FSM IDLE; no beats after rstn goes high.
// 6. With QSN_SCHED_SHIFT_CHECK_EN defined, s=15 accepted -> left=0, merge_sel=14'h3FFF, shift_err=1 and it remains 1.

Source files
------------

// File: rtl/qsn_shift_sched_pc15.sv
// ---------------------------------------------------------------------------
// qsn_shift_sched_pc15
// Scheduler/controller for the Pc=15 QSN cyclic shifter (left shifter, right
// shifter and 15-lane merge stage). Two requesters (req0 = VNU side, req1 =
// CNU side) share the network. Requests are arbitrated round-robin and the
// winner locks the network for len+1 beats. Shift amounts and merge select
// are registered at accept and held for the whole burst (and through IDLE).
//
// Optional feature macro: QSN_SCHED_SHIFT_CHECK_EN
//   When defined, an accepted shift >= PC is replaced by 0 and the sticky
//   shift_err output is raised the cycle after that accept.
//
// Ports
//   sys_clk, rstn            clock (rising edge), async active-low reset
//   reqX_valid/shift/len     burst request from requester X (len = beats-1)
//   reqX_ready               request of X accepted this cycle (combinational)
//   left_shift, right_shift  shifter amounts s and (s==0 ? 0 : PC-s)
//   merge_sel                bit i = 1 iff i < PC-1-s
//   net_valid                current beat is valid
//   net_owner                requester owning the current beat
//   net_last                 final beat of the burst
//   busy                     FSM state (1 = BUSY, 0 = IDLE)
//   shift_err                sticky out-of-range shift flag (macro only)
//
// Handshake: a request transfers in the cycle where reqX_valid && reqX_ready.
// ready is offered only in IDLE or in the last beat of a burst, and only to
// the requester that wins arbitration; requesters hold valid and fields
// stable until they see ready.
// ---------------------------------------------------------------------------
module qsn_shift_sched_pc15 #(
    parameter int PC      = 15,
    parameter int SHIFT_W = 4,
    parameter int LEN_W   = 6
) (
    input  logic               sys_clk,
    input  logic               rstn,
    input  logic               req0_valid,
    input  logic [SHIFT_W-1:0] req0_shift,
    input  logic [LEN_W-1:0]   req0_len,
    output logic               req0_ready,
    input  logic               req1_valid,
    input  logic [SHIFT_W-1:0] req1_shift,
    input  logic [LEN_W-1:0]   req1_len,
    output logic               req1_ready,
    output logic [SHIFT_W-1:0] left_shift,
    output logic [SHIFT_W-1:0] right_shift,
    output logic [PC-2:0]      merge_sel,
    output logic               net_valid,
    output logic               net_owner,
    output logic               net_last,
    output logic               busy
`ifdef QSN_SCHED_SHIFT_CHECK_EN
    ,
    output logic               shift_err
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [LEN_W-1:0]   cnt;
    logic               rr_ptr;

    logic               any_valid;
    logic               grant;
    logic               last_beat;
    logic               accept;
    logic [SHIFT_W-1:0] sel_shift;
    logic [LEN_W-1:0]   sel_len;
    logic [SHIFT_W-1:0] s_eff;
    logic [SHIFT_W-1:0] right_nxt;
    logic [PC-2:0]      merge_nxt;
`ifdef QSN_SCHED_SHIFT_CHECK_EN
    logic               shift_oor;
`endif

    // Arbitration and accept window. A lone requester always wins; on a
    // tie the round-robin pointer decides.
    always_comb begin
        any_valid = req0_valid | req1_valid;
        grant     = (req0_valid && req1_valid) ? rr_ptr : req1_valid;
        last_beat = (state == BUSY) && (cnt == '0);
        accept    = any_valid && ((state == IDLE) || last_beat);
        sel_shift = grant ? req1_shift : req0_shift;
        sel_len   = grant ? req1_len   : req0_len;
    end

    // Effective shift and the derived shifter/merge settings.
    always_comb begin
`ifdef QSN_SCHED_SHIFT_CHECK_EN
        shift_oor = int'(sel_shift) >= PC;
        s_eff     = shift_oor ? '0 : sel_shift;
`else
        s_eff     = sel_shift;
`endif
        right_nxt = (s_eff == '0) ? '0 : SHIFT_W'(PC - int'(s_eff));
        merge_nxt = '0;
        for (int i = 0; i < PC - 1; i++) begin
            merge_nxt[i] = (i + int'(s_eff)) < (PC - 1);
        end
    end

    // FSM: state register
    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = BUSY;
            BUSY:    if (last_beat && !accept) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        req0_ready = accept && !grant;
        req1_ready = accept && grant;
        busy       = (state == BUSY);
        net_valid  = (state == BUSY);
        net_last   = last_beat;
    end

    // Burst datapath. The counter loads len at accept (so a back-to-back
    // accept in the last beat reloads it directly) and stops at 0.
    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            cnt         <= '0;
            rr_ptr      <= 1'b0;
            left_shift  <= '0;
            right_shift <= '0;
            merge_sel   <= '0;
            net_owner   <= 1'b0;
        end else if (accept) begin
            cnt         <= sel_len;
            rr_ptr      <= ~grant;
            left_shift  <= s_eff;
            right_shift <= right_nxt;
            merge_sel   <= merge_nxt;
            net_owner   <= grant;
        end else if ((state == BUSY) && (cnt != '0)) begin
            cnt <= cnt - LEN_W'(1);
        end
    end

`ifdef QSN_SCHED_SHIFT_CHECK_EN
    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            shift_err <= 1'b0;
        end else if (accept && shift_oor) begin
            shift_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_qsn_shift_sched_pc15.sv
// ---------------------------------------------------------------------------
// Testbench for qsn_shift_sched_pc15. Requests are queued per requester; a
// driver presents them, and a reference model predicts grants, readies and
// the full stream of expected beats from the arbitration rules and plain
// arithmetic on the shift factor.
// ---------------------------------------------------------------------------
module tb_qsn_shift_sched_pc15;

    logic        sys_clk;
    logic        rstn;
    logic        req0_valid;
    logic [3:0]  req0_shift;
    logic [5:0]  req0_len;
    logic        req0_ready;
    logic        req1_valid;
    logic [3:0]  req1_shift;
    logic [5:0]  req1_len;
    logic        req1_ready;
    logic [3:0]  left_shift;
    logic [3:0]  right_shift;
    logic [13:0] merge_sel;
    logic        net_valid;
    logic        net_owner;
    logic        net_last;
    logic        busy;
`ifdef QSN_SCHED_SHIFT_CHECK_EN
    logic        shift_err;
`endif

    qsn_shift_sched_pc15 dut (
        .sys_clk     (sys_clk),
        .rstn        (rstn),
        .req0_valid  (req0_valid),
        .req0_shift  (req0_shift),
        .req0_len    (req0_len),
        .req0_ready  (req0_ready),
        .req1_valid  (req1_valid),
        .req1_shift  (req1_shift),
        .req1_len    (req1_len),
        .req1_ready  (req1_ready),
        .left_shift  (left_shift),
        .right_shift (right_shift),
        .merge_sel   (merge_sel),
        .net_valid   (net_valid),
        .net_owner   (net_owner),
        .net_last    (net_last),
        .busy        (busy)
`ifdef QSN_SCHED_SHIFT_CHECK_EN
        ,
        .shift_err   (shift_err)
`endif
    );

    // ---------------- clock ----------------
    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // ---------------- bench state ----------------
    int checks = 0;
    int errors = 0;

    logic [9:0]  pend0_q[$];   // {shift, len}
    logic [9:0]  pend1_q[$];
    logic [23:0] exp_q[$];     // {owner, last, left, right, merge}
    logic        own_log[$];
    logic        v0 = 1'b0;
    logic        v1 = 1'b0;
    logic        m_ptr = 1'b0;
    logic        m_err = 1'b0;
    bit          rand_mode = 1'b0;

    // Expected beat from shift factor: right = 15-s (0 for s=0), merge has
    // the low 14-s bits set.
    function automatic logic [23:0] make_beat(logic owner, logic last, int s);
        int r;
        int m;
        r = (s == 0) ? 0 : 15 - s;
        m = (1 << (14 - s)) - 1;
        return {owner, last, 4'(s), 4'(r), 14'(m)};
    endfunction

    // ---------------- driver ----------------
    task automatic drive_inputs();
        if (!v0 && pend0_q.size() > 0 && (!rand_mode || $urandom_range(0, 1) == 1)) v0 = 1'b1;
        if (!v1 && pend1_q.size() > 0 && (!rand_mode || $urandom_range(0, 1) == 1)) v1 = 1'b1;
        req0_valid = v0;
        req1_valid = v1;
        {req0_shift, req0_len} = v0 ? pend0_q[0] : 10'($urandom_range(0, 1023));
        {req1_shift, req1_len} = v1 ? pend1_q[0] : 10'($urandom_range(0, 1023));
    endtask

    // ---------------- model + scoreboard (one cycle) ----------------
    task automatic check_cycle();
        logic [23:0] exp_b;
        logic [23:0] act_b;
        logic        exp_v;
        logic        g;
        logic        acc;
        logic [9:0]  req;
        int          s;
        int          len;
        exp_b = '0;
        exp_v = 1'b0;
        if (exp_q.size() > 0) begin
            exp_b = exp_q.pop_front();
            exp_v = 1'b1;
        end
        checks++;
        if (net_valid !== exp_v) begin
            errors++;
            $display("FAIL net_valid: got %b expected %b at %0t", net_valid, exp_v, $time);
        end
        if (exp_v) begin
            act_b = {net_owner, net_last, left_shift, right_shift, merge_sel};
            own_log.push_back(net_owner);
            checks++;
            if (act_b !== exp_b) begin
                errors++;
                $display("FAIL beat: got owner=%b last=%b l=%0d r=%0d m=%h expected owner=%b last=%b l=%0d r=%0d m=%h at %0t",
                         act_b[23], act_b[22], act_b[21:18], act_b[17:14], act_b[13:0],
                         exp_b[23], exp_b[22], exp_b[21:18], exp_b[17:14], exp_b[13:0], $time);
            end
        end
        // Accept window: network idle or showing its last beat now.
        g   = (v0 && v1) ? m_ptr : v1;
        acc = (exp_q.size() == 0) && (v0 || v1);
        checks++;
        if ({req0_ready, req1_ready} !== {acc && !g, acc && g}) begin
            errors++;
            $display("FAIL ready: got r0=%b r1=%b expected r0=%b r1=%b at %0t",
                     req0_ready, req1_ready, acc && !g, acc && g, $time);
        end
`ifdef QSN_SCHED_SHIFT_CHECK_EN
        checks++;
        if (shift_err !== m_err) begin
            errors++;
            $display("FAIL shift_err: got %b expected %b at %0t", shift_err, m_err, $time);
        end
`endif
        if (acc) begin
            if (g) begin
                req = pend1_q.pop_front();
                v1  = 1'b0;
            end else begin
                req = pend0_q.pop_front();
                v0  = 1'b0;
            end
            s   = int'(req[9:6]);
            len = int'(req[5:0]);
`ifdef QSN_SCHED_SHIFT_CHECK_EN
            if (s >= 15) begin
                s     = 0;
                m_err = 1'b1;
            end
`endif
            for (int k = 0; k <= len; k++) exp_q.push_back(make_beat(g, k == len, s));
            m_ptr = !g;
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
        drive_inputs();
        @(negedge sys_clk);
        check_cycle();
    endtask

    task automatic run_drain(int budget);
        int n;
        n = 0;
        while ((pend0_q.size() > 0 || pend1_q.size() > 0 || v0 || v1 || exp_q.size() > 0) && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending beats expected 0 after %0d cycles", exp_q.size(), budget);
        end
        step(); // one idle cycle: net_valid must drop
    endtask

    task automatic do_reset();
        @(negedge sys_clk);
        #2;
        rstn = 1'b0;
        v0 = 1'b0;
        v1 = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        pend0_q.delete();
        pend1_q.delete();
        exp_q.delete();
        own_log.delete();
        m_ptr = 1'b0;
        m_err = 1'b0;
        repeat (2) @(negedge sys_clk);
        #2;
        rstn = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rstn = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_shift = '0;
        req1_shift = '0;
        req0_len = '0;
        req1_len = '0;
        repeat (3) @(negedge sys_clk);
        checks++; if (left_shift !== 4'd0) begin errors++; $display("FAIL rst_left: got %0d expected 0", left_shift); end
        checks++; if (right_shift !== 4'd0) begin errors++; $display("FAIL rst_right: got %0d expected 0", right_shift); end
        checks++; if (merge_sel !== 14'h0) begin errors++; $display("FAIL rst_merge: got %h expected 0", merge_sel); end
        checks++; if (net_valid !== 1'b0) begin errors++; $display("FAIL rst_net_valid: got %b expected 0", net_valid); end
        checks++; if (net_owner !== 1'b0) begin errors++; $display("FAIL rst_net_owner: got %b expected 0", net_owner); end
        checks++; if (net_last !== 1'b0) begin errors++; $display("FAIL rst_net_last: got %b expected 0", net_last); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
        checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL rst_ready: got %b expected 00", {req0_ready, req1_ready}); end
        #2;
        rstn = 1'b1;
    endtask

    task automatic test_basic();
        do_reset();
        pend0_q.push_back({4'd3, 6'd2});
        run_drain(50);
        checks++;
        if ({left_shift, right_shift, merge_sel} !== {4'd3, 4'd12, 14'h07FF}) begin
            errors++;
            $display("FAIL basic_hold: got l=%0d r=%0d m=%h expected l=3 r=12 m=07ff", left_shift, right_shift, merge_sel);
        end
        checks++;
        if (own_log.size() != 3) begin
            errors++;
            $display("FAIL basic_beats: got %0d expected 3", own_log.size());
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        pend0_q.push_back({4'd5, 6'd1});
        pend1_q.push_back({4'd9, 6'd2});
        run_drain(50);
        checks++;
        if (own_log.size() != 5 || own_log[0] !== 1'b0 || own_log[2] !== 1'b1) begin
            errors++;
            $display("FAIL b2b_owner: got %0d beats expected 5 beats owner 0 then 1", own_log.size());
        end
    endtask

    task automatic test_alternate();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            pend0_q.push_back({4'($urandom_range(0, 14)), 6'd0});
            pend1_q.push_back({4'($urandom_range(0, 14)), 6'd0});
        end
        run_drain(50);
        checks++;
        if (own_log.size() != 8) begin
            errors++;
            $display("FAIL alt_count: got %0d expected 8", own_log.size());
        end
        for (int i = 0; i < own_log.size(); i++) begin
            checks++;
            if (own_log[i] !== 1'(i % 2)) begin
                errors++;
                $display("FAIL alt_owner: beat %0d got %b expected %b", i, own_log[i], 1'(i % 2));
            end
        end
    endtask

    task automatic test_shift_edges();
        do_reset();
        pend0_q.push_back({4'd0, 6'd0});
        run_drain(50);
        checks++;
        if ({left_shift, right_shift, merge_sel} !== {4'd0, 4'd0, 14'h3FFF}) begin
            errors++;
            $display("FAIL s0_hold: got l=%0d r=%0d m=%h expected l=0 r=0 m=3fff", left_shift, right_shift, merge_sel);
        end
        pend1_q.push_back({4'd14, 6'd1});
        run_drain(50);
        checks++;
        if ({left_shift, right_shift, merge_sel} !== {4'd14, 4'd1, 14'h0000}) begin
            errors++;
            $display("FAIL s14_hold: got l=%0d r=%0d m=%h expected l=14 r=1 m=0000", left_shift, right_shift, merge_sel);
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        pend1_q.push_back({4'd6, 6'd4});
        step(); // accept
        step(); // beat 1
        step(); // beat 2
        #2;
        rstn = 1'b0;
        #1;
        checks++;
        if ({left_shift, right_shift, merge_sel, net_valid, net_owner, net_last, busy} !== 26'd0) begin
            errors++;
            $display("FAIL async_rst: got l=%0d r=%0d m=%h v=%b o=%b last=%b busy=%b expected all 0",
                     left_shift, right_shift, merge_sel, net_valid, net_owner, net_last, busy);
        end
        exp_q.delete();
        own_log.delete();
        m_ptr = 1'b0;
        m_err = 1'b0;
        repeat (2) @(negedge sys_clk);
        #2;
        rstn = 1'b1;
        repeat (5) step();
        checks++;
        if (own_log.size() != 0) begin
            errors++;
            $display("FAIL no_resume: got %0d beats expected 0", own_log.size());
        end
    endtask

    task automatic test_random();
        do_reset();
        rand_mode = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 1)
                pend1_q.push_back({4'($urandom_range(0, 14)), 6'($urandom_range(0, 7))});
            else
                pend0_q.push_back({4'($urandom_range(0, 14)), 6'($urandom_range(0, 7))});
        end
        pend0_q.push_back({4'($urandom_range(0, 14)), 6'd63});
        run_drain(3000);
        rand_mode = 1'b0;
    endtask

`ifdef QSN_SCHED_SHIFT_CHECK_EN
    task automatic test_shift_check();
        do_reset();
        pend0_q.push_back({4'd15, 6'd1});
        run_drain(50);
        checks++;
        if ({left_shift, merge_sel, shift_err} !== {4'd0, 14'h3FFF, 1'b1}) begin
            errors++;
            $display("FAIL shift_chk: got l=%0d m=%h err=%b expected l=0 m=3fff err=1", left_shift, merge_sel, shift_err);
        end
        pend1_q.push_back({4'd4, 6'd0});
        run_drain(50);
        checks++;
        if (shift_err !== 1'b1) begin
            errors++;
            $display("FAIL shift_err_sticky: got %b expected 1", shift_err);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_alternate();
        test_shift_edges();
        test_reset_mid_burst();
        test_random();
`ifdef QSN_SCHED_SHIFT_CHECK_EN
        test_shift_check();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
